// File: rtl/mem_arbiter_ctrl.sv
// ============================================================================
//  Module      : mem_arbiter_ctrl
//  Description : Two-port (I-cache / D-cache) arbiter in front of a single
//                fixed-latency word memory, with I-side starvation guard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter_ctrl #(
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam logic [3:0]    CNT_LOAD   = 4'(LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_arbiter_ctrl: LATENCY must be in 1..15");
    end
    if (DEPTH < 2 || AW >= 32) begin : g_bad_depth
      $error("mem_arbiter_ctrl: DEPTH out of supported range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          sel_dport_q, sel_dport_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  // Main storage; deliberately excluded from reset so contents survive rst.
  logic [31:0]   mem [DEPTH];

  logic          starve_hit;
  logic          pick_dport;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_addr_mod;
  logic          access;
  logic          mem_we;
  logic [31:0]   mem_word;
  logic          unused_addr_hi;

  // I wins only once D has been granted MAX_STARVE times in a row over it.
  assign starve_hit   = i_req && (starve_q == STARVE_MAX);
  assign pick_dport   = d_req && !starve_hit;
  assign sel_addr     = pick_dport ? d_addr : i_addr;
  assign sel_addr_mod = sel_addr % 32'(DEPTH);
  assign unused_addr_hi = ^sel_addr_mod[31:AW];

  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we   = access && sel_dport_q && we_q;
  assign mem_word = mem[addr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    sel_dport_d = sel_dport_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d     = BUSY;
          cnt_d       = CNT_LOAD;
          sel_dport_d = pick_dport;
          we_d        = pick_dport && d_we;
          addr_d      = sel_addr_mod[AW-1:0];
          wdata_d     = d_wdata;
          if (pick_dport && i_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end

      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (sel_dport_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = we_q ? wdata_q : mem_word;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_word;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      starve_q    <= '0;
      sel_dport_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      sel_dport_q <= sel_dport_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // An async reset drops the state to IDLE, so an aborted transfer never writes.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign i_ack    = i_ack_q;
  assign d_ack    = d_ack_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign mem_busy = (state_q != IDLE);

  a_ack_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(i_ack_q && d_ack_q));

  a_ack_single_cycle : assert property (@(posedge clk) disable iff (rst)
    (i_ack_q || d_ack_q) |=> !(i_ack_q || d_ack_q));

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_ctrl.sv
// ============================================================================
//  Module      : tb_mem_arbiter_ctrl
//  Description : Directed self-checking bench for mem_arbiter_ctrl with a
//                transaction-timing reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter_ctrl;

  localparam int DEPTH      = 1024;
  localparam int LATENCY    = 2;
  localparam int MAX_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dack_cnt = 0;

  byte ack_port [$];
  int  ack_cyc  [$];

  mem_arbiter_ctrl #(
    .DEPTH      (DEPTH),
    .LATENCY    (LATENCY),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_busy (mem_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transfer at a time, timed in cycles since the grant.
  logic [31:0] m_mem [int];
  bit          m_busy   = 1'b0;
  bit          m_dport  = 1'b0;
  bit          m_we     = 1'b0;
  int          m_k      = 0;
  int          m_starve = 0;
  logic [31:0] m_addr   = 32'd0;
  logic [31:0] m_wdata  = 32'd0;
  logic        e_iack   = 1'b0;
  logic        e_dack   = 1'b0;
  logic [31:0] e_irdata = 32'd0;
  logic [31:0] e_drdata = 32'd0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   = 1'b0;
      m_k      = 0;
      m_starve = 0;
      e_iack   = 1'b0;
      e_dack   = 1'b0;
      e_irdata = 32'd0;
      e_drdata = 32'd0;
    end else begin
      e_iack = 1'b0;
      e_dack = 1'b0;
      if (!m_busy) begin
        if (i_req || d_req) begin
          m_dport = d_req && !(i_req && m_starve == MAX_STARVE);
          if (m_dport && i_req) m_starve = (m_starve < MAX_STARVE) ? m_starve + 1 : MAX_STARVE;
          else                  m_starve = 0;
          m_addr  = (m_dport ? d_addr : i_addr) % 32'(DEPTH);
          m_we    = m_dport && d_we;
          m_wdata = d_wdata;
          m_busy  = 1'b1;
          m_k     = 0;
        end
      end else begin
        m_k++;
        if (m_k == LATENCY) begin
          if (m_dport) begin
            e_dack = 1'b1;
            if (m_we) begin
              m_mem[int'(m_addr)] = m_wdata;
              e_drdata = m_wdata;
            end else begin
              e_drdata = m_read(m_addr);
            end
          end else begin
            e_iack   = 1'b1;
            e_irdata = m_read(m_addr);
          end
        end else if (m_k == LATENCY + 1) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check1("mem_busy", mem_busy, m_busy);
    check1("i_ack", i_ack, e_iack);
    check1("d_ack", d_ack, e_dack);
    check32("i_rdata", i_rdata, e_irdata);
    check32("d_rdata", d_rdata, e_drdata);
    check1("ack_exclusive", i_ack && d_ack, 1'b0);
    if (d_ack) begin
      dack_cnt++;
      ack_port.push_back("D");
      ack_cyc.push_back(cyc);
    end
    if (i_ack) begin
      ack_port.push_back("I");
      ack_cyc.push_back(cyc);
    end
  end

  task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input bit mutate, input logic [31:0] a2, input logic [31:0] wd2,
                       output logic [31:0] rd, output int ack_c);
    int n;
    @(negedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mutate && n == 1) begin
        #1; d_addr = a2; d_wdata = wd2;
      end
    end while (!d_ack && n < 40);
    if (!d_ack) begin
      checks++; failures++;
      $display("FAIL d_timeout: got no d_ack within %0d cycles", n);
    end
    rd = d_rdata; ack_c = cyc;
    #1; d_req = 1'b0;
  endtask

  task automatic i_txn(input logic [31:0] a, output logic [31:0] rd,
                       output int req_c, output int ack_c, output int busy_n);
    int n;
    @(negedge clk); #1;
    i_req = 1'b1; i_addr = a; req_c = cyc;
    n = 0; busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_busy) busy_n++;
    end while (!i_ack && n < 40);
    if (!i_ack) begin
      checks++; failures++;
      $display("FAIL i_timeout: got no i_ack within %0d cycles", n);
    end
    rd = i_rdata; ack_c = cyc;
    #1; i_req = 1'b0;
  endtask

  task automatic d_burst_reads(input logic [31:0] a, input int count);
    int n;
    @(negedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = a;
    for (int k = 0; k < count; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!d_ack && n < 40);
      if (!d_ack) begin
        checks++; failures++;
        $display("FAIL burst_timeout: got no d_ack for read %0d", k);
      end
    end
    #1; d_req = 1'b0;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] rd, rd2;
    int rq, ac, ac2, bn, bn2, dcnt0;
    string seq;

    repeat (2) @(negedge clk);
    check1("reset_busy", mem_busy, 1'b0);
    check32("reset_d_rdata", d_rdata, 32'd0);
    #1; rst = 1'b0;

    // Seed Mem[5], then the canonical I read.
    d_txn(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, rd, ac);
    i_txn(32'd5, rd, rq, ac, bn);
    check32("i_read_data", rd, 32'hDEADBEEF);
    check32("i_ack_latency", 32'(ac - (rq + 1)), 32'(LATENCY));
    check32("i_busy_cycles", 32'(bn), 32'd3);

    // Aliased write then read through the low address bits.
    d_txn(1'b1, 32'h407, 32'h12345678, 1'b0, 32'd0, 32'd0, rd, ac);
    d_txn(1'b0, 32'd7, 32'd0, 1'b0, 32'd0, 32'd0, rd, ac);
    check32("alias_d_read", rd, 32'h12345678);
    i_txn(32'hABCD0007, rd, rq, ac, bn);
    check32("alias_i_read", rd, 32'h12345678);

    // Simultaneous requests: D first, I exactly LATENCY+2 later.
    d_txn(1'b1, 32'd9, 32'h00000099, 1'b0, 32'd0, 32'd0, rd, ac);
    fork
      d_txn(1'b0, 32'd9, 32'd0, 1'b0, 32'd0, 32'd0, rd, ac);
      i_txn(32'd5, rd2, rq, ac2, bn2);
    join
    check32("simul_d_data", rd, 32'h00000099);
    check32("simul_i_data", rd2, 32'hDEADBEEF);
    check32("simul_gap", 32'(ac2 - ac), 32'(LATENCY + 2));

    // Starvation guard: four D grants, one I grant, then D resumes.
    ack_port.delete(); ack_cyc.delete();
    fork
      d_burst_reads(32'd7, 6);
      i_txn(32'd5, rd2, rq, ac2, bn2);
    join
    seq = "";
    foreach (ack_port[k]) seq = {seq, string'(ack_port[k])};
    checks++;
    if (seq != "DDDDIDD") begin
      failures++;
      $display("FAIL starve_order: got %s expected DDDDIDD", seq);
    end
    check32("starve_i_data", rd2, 32'hDEADBEEF);

    // Reset during BUSY aborts the write and leaves Mem intact.
    d_txn(1'b1, 32'd3, 32'h11111111, 1'b0, 32'd0, 32'd0, rd, ac);
    dcnt0 = dack_cnt;
    @(negedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd3; d_wdata = 32'hAAAA0000;
    @(negedge clk);
    @(negedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    check1("rst_busy_low", mem_busy, 1'b0);
    #1; rst = 1'b0;
    @(negedge clk);
    check32("rst_no_dack", 32'(dack_cnt - dcnt0), 32'd0);
    d_txn(1'b0, 32'd3, 32'd0, 1'b0, 32'd0, 32'd0, rd, ac);
    check32("rst_mem_kept", rd, 32'h11111111);

    // Address/data changed after the grant must not affect the write.
    d_txn(1'b1, 32'd11, 32'h00000000, 1'b0, 32'd0, 32'd0, rd, ac);
    d_txn(1'b1, 32'd10, 32'hCAFE0001, 1'b1, 32'd11, 32'hBAD00BAD, rd, ac);
    check32("latch_write_ack_data", rd, 32'hCAFE0001);
    d_txn(1'b0, 32'd10, 32'd0, 1'b0, 32'd0, 32'd0, rd, ac);
    check32("latch_addr10", rd, 32'hCAFE0001);
    d_txn(1'b0, 32'd11, 32'd0, 1'b0, 32'd0, 32'd0, rd, ac);
    check32("latch_addr11", rd, 32'h00000000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter_ctrl.md
MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, giving the number of 32-bit words of main memory.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the access latency in cycles; legal range is 1..15.
REQ-003 The block SHALL have parameter MAX_STARVE, default 4, giving the number of consecutive D-grants allowed while I is pending.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port i_req, input, 1 bit: I-cache miss read request, held until i_ack.
REQ-008 The block SHALL have port i_addr, input, 32 bits: I-cache word address.
REQ-009 The block SHALL have port i_rdata, output, 32 bits: read data, valid only while i_ack is high.
REQ-010 The block SHALL have port i_ack, output, 1 bit: one-cycle completion pulse for the I-cache.
REQ-011 The block SHALL have port d_req, input, 1 bit: D-cache request, held until d_ack.
REQ-012 The block SHALL have port d_we, input, 1 bit: 1 means write, 0 means read.
REQ-013 The block SHALL have port d_addr, input, 32 bits: D-cache word address.
REQ-014 The block SHALL have port d_wdata, input, 32 bits: write data.
REQ-015 The block SHALL have port d_rdata, output, 32 bits: read data, valid only while d_ack is high.
REQ-016 The block SHALL have port d_ack, output, 1 bit: one-cycle completion pulse for the D-cache.
REQ-017 The block SHALL have port mem_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly three states, IDLE, BUSY and RESP, held in a state register.
REQ-019 Requests SHALL be sampled only in IDLE.
REQ-020 On an edge in IDLE with any request pending, the block SHALL grant the request, latch port, address, d_we and d_wdata, load the counter with LATENCY-1, and go to BUSY.
REQ-021 Arbitration SHALL give priority to D over I, except when starve_cnt equals MAX_STARVE and i_req is high, in which case I SHALL be granted.
REQ-022 starve_cnt SHALL increment on each D-grant made while i_req is high, saturating at MAX_STARVE.
REQ-023 starve_cnt SHALL clear to 0 on each I-grant and on each D-grant made while i_req is low.
REQ-024 In BUSY with counter 0, the block SHALL go to RESP on the next edge and perform the memory access on that same edge; otherwise it SHALL decrement the counter.
REQ-025 The access SHALL use the latched address modulo DEPTH; upper address bits SHALL be ignored.
REQ-026 A D write SHALL commit Mem at that edge, and d_rdata SHALL equal the latched d_wdata during the ack cycle.
REQ-027 A read SHALL present the Mem word on the granted port's rdata.
REQ-028 In RESP, the granted port's ack SHALL be high for exactly one cycle, and the state SHALL return to IDLE on the next edge without sampling requests.
REQ-029 Latency SHALL be exactly LATENCY cycles from the grant edge to ack rising, and the minimum spacing between grants SHALL be LATENCY+2 cycles.
REQ-030 i_ack and d_ack SHALL never be high together.
REQ-031 The non-granted port's ack SHALL stay low.
REQ-032 Each rdata output SHALL hold its last value outside its own ack cycle.
REQ-033 i_req and d_req rising on the same IDLE edge SHALL be resolved by REQ-021.
REQ-034 The losing request SHALL stay pending and be served in the next IDLE with no loss.
REQ-035 Address, d_we and d_wdata changes after the grant edge SHALL have no effect on the transfer in progress.
REQ-036 A request withdrawn after its grant edge SHALL still complete and ack.

Reset
REQ-037 When rst is high, the block SHALL asynchronously force state=IDLE, counter=0, starve_cnt=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0 and mem_busy=0.
REQ-038 A reset asserted during BUSY SHALL abort the transfer with no Mem write and no ack.
REQ-039 Reset SHALL NOT clear Mem contents.
REQ-040 After rst deasserts, the first sampling SHALL occur on the first rising edge, from IDLE.

Verification
REQ-041 With LATENCY=2 and Mem[5]=0xDEADBEEF, an i_req for addr 5 granted at edge N SHALL give i_ack high in cycle N+2 with i_rdata=0xDEADBEEF and mem_busy high for 3 cycles.
REQ-042 A d write of addr 0x407 with data 0x12345678 (DEPTH=1024) followed by a d read of addr 7 SHALL return 0x12345678, and Mem[7] SHALL equal 0x12345678.
REQ-043 i_req and d_req asserted together SHALL give d_ack first; i_ack SHALL follow exactly LATENCY+2 cycles later.
REQ-044 With d_req held continuously high and i_req high, 4 D-grants SHALL occur, then 1 I-grant, then D-grants resume.
REQ-045 A d write to addr 3 with data 0xAAAA0000 over Mem[3]=0x11111111, with rst pulsed one cycle after the grant, SHALL leave d_ack never high, Mem[3]=0x11111111, and state IDLE.
REQ-046 Changing d_addr and d_wdata one cycle after the grant SHALL write the originally latched address and data.
